// File: rtl/smoke_timebase.sv
// Clock-domain timebase: synchronised, stretched reset release, free-running cycle
// counter and a single-outstanding wait-N-cycles request/done handshake.
module smoke_timebase #(
   parameter int CNT_WIDTH  = 32,
   parameter int REQ_WIDTH  = 16,
   parameter int RST_CYCLES = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   output logic                 ready,
   output logic [CNT_WIDTH-1:0] cycle_count,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [REQ_WIDTH-1:0] req_cycles,
   output logic                 done_valid,
   input  logic                 done_ready,
   output logic [CNT_WIDTH-1:0] done_cycle,
   output logic                 busy
);
   localparam int HW = $clog2(RST_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES);

   typedef enum logic [1:0] {RST_HOLD, IDLE, WAIT, DONE} state_t;

   state_t               state, state_nxt;
   logic [1:0]           rst_sync;
   logic [HW-1:0]        hold_cnt;
   logic [REQ_WIDTH-1:0] remaining, remaining_nxt;
   logic                 enter_done;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync    <= '0;
         hold_cnt    <= '0;
         state       <= RST_HOLD;
         remaining   <= '0;
         cycle_count <= '0;
         done_cycle  <= '0;
      end else begin
         rst_sync  <= {rst_sync[0], 1'b1};
         state     <= state_nxt;
         remaining <= remaining_nxt;
         // hold counts only clocks seen after the synchroniser has released
         if (state == RST_HOLD && rst_sync[1] && hold_cnt != HOLD_LAST)
            hold_cnt <= hold_cnt + 1'b1;
         if (ready)
            cycle_count <= cycle_count + CNT_WIDTH'(1);
         if (enter_done)
            done_cycle <= cycle_count + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      enter_done    = 1'b0;
      case (state)
         RST_HOLD: if (rst_sync[1] && hold_cnt == HOLD_LAST) state_nxt = IDLE;
         IDLE: begin
            // a zero-length wait still takes one clock, same as a one-cycle wait
            if (req_valid) begin
               state_nxt     = WAIT;
               remaining_nxt = (req_cycles == '0) ? REQ_WIDTH'(1) : req_cycles;
            end
         end
         WAIT: begin
            if (remaining == REQ_WIDTH'(1)) begin
               state_nxt  = DONE;
               enter_done = 1'b1;
            end else begin
               remaining_nxt = remaining - REQ_WIDTH'(1);
            end
         end
         DONE:    if (done_ready) state_nxt = IDLE;
         default: state_nxt = RST_HOLD;
      endcase
   end

   assign ready      = (state != RST_HOLD);
   assign req_ready  = (state == IDLE);
   assign done_valid = (state == DONE);
   assign busy       = (state == WAIT) || (state == DONE);
endmodule
